// File: rtl/rename_pkg.sv
// +------------------------------------------------------------------------+
// | rename_pkg: shared widths, map types and constants for the rename RAT. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package rename_pkg;

  localparam int ZERO_AR      = 0;
  localparam int AR_NUM_DEF   = 32;
  localparam int PR_NUM_DEF   = 64;
  localparam int CKPT_NUM_DEF = 4;

  // Index width of an n-entry table; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ar_width(input int ar_num);
    return idx_w(ar_num);
  endfunction

  function automatic int pr_width(input int pr_num);
    return idx_w(pr_num);
  endfunction

  function automatic int ck_width(input int ckpt_num);
    return idx_w(ckpt_num);
  endfunction

  typedef logic [ar_width(AR_NUM_DEF)-1:0]   ar_t;
  typedef logic [pr_width(PR_NUM_DEF)-1:0]   pr_t;
  typedef logic [ck_width(CKPT_NUM_DEF)-1:0] ckpt_id_t;

endpackage

`default_nettype wire

// File: rtl/rat_group_bypass.sv
// +------------------------------------------------------------------------+
// | rat_group_bypass: youngest earlier-slot dest match, else table value.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rat_group_bypass
  import rename_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AR_W  = 5,
  parameter int PR_W  = 6,
  parameter int LIM_W = 3
) (
  input  logic [LIM_W-1:0]      limit,
  input  logic [AR_W-1:0]       key,
  input  logic [SLOTS-1:0]      dest_en,
  input  logic [SLOTS*AR_W-1:0] dest_ar,
  input  logic [SLOTS*PR_W-1:0] dest_pr,
  input  logic [PR_W-1:0]       table_pr,
  output logic [PR_W-1:0]       pr
);

  // Only slots below limit are older than the requester; later matches override.
  always_comb begin
    pr = table_pr;
    for (int m = 0; m < SLOTS; m++) begin
      if ((m < int'(limit)) && dest_en[m] && (dest_ar[m*AR_W +: AR_W] == key)) begin
        pr = dest_pr[m*PR_W +: PR_W];
      end
    end
    if (key == AR_W'(ZERO_AR)) begin
      pr = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rat_ckpt.sv
// +------------------------------------------------------------------------+
// | rat_ckpt: speculative/architectural RAT with branch checkpoints.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module rat_ckpt
  import rename_pkg::*;
#(
  parameter  int RENAME_W = 4,
  parameter  int RETIRE_W = 4,
  parameter  int AR_NUM   = 32,
  parameter  int PR_NUM   = 64,
  parameter  int CKPT_NUM = 4,
  localparam int AR_W     = ar_width(AR_NUM),
  localparam int PR_W     = pr_width(PR_NUM),
  localparam int CK_W     = ck_width(CKPT_NUM),
  localparam int SL_W     = idx_w(RENAME_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [RENAME_W-1:0]        ren_dest_en,
  input  logic [RENAME_W*AR_W-1:0]   ren_dest_ar,
  input  logic [RENAME_W*PR_W-1:0]   ren_dest_pr,
  input  logic [2*RENAME_W*AR_W-1:0] ren_src_ar,
  output logic [2*RENAME_W*PR_W-1:0] ren_src_pr,
  output logic [RENAME_W*PR_W-1:0]   ren_old_pr,
  input  logic                       ckpt_alloc,
  input  logic [SL_W-1:0]            ckpt_slot,
  output logic [CK_W-1:0]            ckpt_id,
  output logic                       ckpt_full,
  input  logic                       ckpt_restore,
  input  logic [CK_W-1:0]            ckpt_restore_id,
  input  logic                       ckpt_release,
  input  logic [RETIRE_W-1:0]        ret_dest_en,
  input  logic [RETIRE_W*AR_W-1:0]   ret_dest_ar,
  input  logic [RETIRE_W*PR_W-1:0]   ret_dest_pr
);

  localparam int LIM_W = SL_W + 1;
  localparam int CNT_W = CK_W + 1;

  logic [PR_W-1:0]  srat_q [AR_NUM];
  logic [PR_W-1:0]  srat_d [AR_NUM];
  logic [PR_W-1:0]  arat_q [AR_NUM];
  logic [PR_W-1:0]  arat_d [AR_NUM];
  logic [PR_W-1:0]  ckpt_q [CKPT_NUM][AR_NUM];
  logic [PR_W-1:0]  ckpt_d [CKPT_NUM][AR_NUM];
  logic [PR_W-1:0]  srat_grp   [AR_NUM];
  logic [PR_W-1:0]  snap_merge [AR_NUM];
  logic [CK_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             alloc_ok;
  logic [LIM_W-1:0] merge_lim;

  assign alloc_ok  = ckpt_alloc && !full_q;
  assign merge_lim = LIM_W'(ckpt_slot) + LIM_W'(1);
  assign ckpt_id   = tail_q;
  assign ckpt_full = full_q;

  // Per-AR views of the map: whole group applied, and group up to the branch.
  for (genvar i = 0; i < AR_NUM; i++) begin : g_ar
    rat_group_bypass #(.SLOTS(RENAME_W), .AR_W(AR_W), .PR_W(PR_W), .LIM_W(LIM_W)) u_grp (
      .limit(LIM_W'(RENAME_W)), .key(AR_W'(i)), .dest_en(ren_dest_en),
      .dest_ar(ren_dest_ar), .dest_pr(ren_dest_pr), .table_pr(srat_q[i]), .pr(srat_grp[i])
    );
    rat_group_bypass #(.SLOTS(RENAME_W), .AR_W(AR_W), .PR_W(PR_W), .LIM_W(LIM_W)) u_merge (
      .limit(merge_lim), .key(AR_W'(i)), .dest_en(ren_dest_en),
      .dest_ar(ren_dest_ar), .dest_pr(ren_dest_pr), .table_pr(srat_q[i]), .pr(snap_merge[i])
    );
  end

  for (genvar k = 0; k < RENAME_W; k++) begin : g_slot
    rat_group_bypass #(.SLOTS(RENAME_W), .AR_W(AR_W), .PR_W(PR_W), .LIM_W(LIM_W)) u_old (
      .limit(LIM_W'(k)), .key(ren_dest_ar[k*AR_W +: AR_W]), .dest_en(ren_dest_en),
      .dest_ar(ren_dest_ar), .dest_pr(ren_dest_pr),
      .table_pr(srat_q[ren_dest_ar[k*AR_W +: AR_W]]), .pr(ren_old_pr[k*PR_W +: PR_W])
    );
    for (genvar j = 0; j < 2; j++) begin : g_src
      rat_group_bypass #(.SLOTS(RENAME_W), .AR_W(AR_W), .PR_W(PR_W), .LIM_W(LIM_W)) u_src (
        .limit(LIM_W'(k)), .key(ren_src_ar[(2*k+j)*AR_W +: AR_W]), .dest_en(ren_dest_en),
        .dest_ar(ren_dest_ar), .dest_pr(ren_dest_pr),
        .table_pr(srat_q[ren_src_ar[(2*k+j)*AR_W +: AR_W]]),
        .pr(ren_src_pr[(2*k+j)*PR_W +: PR_W])
      );
    end
  end

  always_comb begin
    arat_d = arat_q;
    for (int r = 0; r < RETIRE_W; r++) begin
      if (ret_dest_en[r] && (ret_dest_ar[r*AR_W +: AR_W] != AR_W'(ZERO_AR))) begin
        arat_d[ret_dest_ar[r*AR_W +: AR_W]] = ret_dest_pr[r*PR_W +: PR_W];
      end
    end
  end

  always_comb begin
    srat_d  = srat_grp;
    ckpt_d  = ckpt_q;
    head_d  = head_q + CK_W'(ckpt_release);
    tail_d  = tail_q;
    count_d = count_q - CNT_W'(ckpt_release);
    if (flush) begin
      // Flush sees this cycle's retirements so no committed mapping is lost.
      srat_d  = arat_d;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (ckpt_restore) begin
      srat_d  = ckpt_q[ckpt_restore_id];
      tail_d  = ckpt_restore_id + CK_W'(1);
      count_d = {1'b0, ckpt_restore_id - head_q} + CNT_W'(1) - CNT_W'(ckpt_release);
    end else if (alloc_ok) begin
      ckpt_d[tail_q] = snap_merge;
      tail_d         = tail_q + CK_W'(1);
      count_d        = count_q + CNT_W'(1) - CNT_W'(ckpt_release);
    end
    full_d = (count_d == CNT_W'(CKPT_NUM));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AR_NUM; i++) begin
        srat_q[i] <= PR_W'(i);
        arat_q[i] <= PR_W'(i);
      end
      for (int c = 0; c < CKPT_NUM; c++) begin
        for (int i = 0; i < AR_NUM; i++) begin
          ckpt_q[c][i] <= PR_W'(i);
        end
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      srat_q  <= srat_d;
      arat_q  <= arat_d;
      ckpt_q  <= ckpt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  a_alloc_when_full: assert property (@(posedge clk) disable iff (rst)
    !(ckpt_alloc && full_q));
  a_release_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(ckpt_release && (count_q == '0)));
  a_restore_released_head: assert property (@(posedge clk) disable iff (rst)
    !(ckpt_restore && ckpt_release && (ckpt_restore_id == head_q)));

endmodule

`default_nettype wire

// File: doc/rat_ckpt.md
# rat_ckpt

Parametrised register alias table for the dispatch stage. It holds a speculative map (sRAT) and an architectural map (aRAT). It renames up to RENAME_W instructions per cycle with intra-group source/old-mapping bypass, and commits up to RETIRE_W mappings per cycle into the aRAT. It also keeps CKPT_NUM branch checkpoints of the sRAT, so a mispredict recovers in one cycle without waiting for the aRAT.

## Interface
- RENAME_W, 4, rename slots per cycle
- RETIRE_W, 4, retire slots per cycle
- AR_NUM, 32, architectural registers; AR_W = clog2(AR_NUM)
- PR_NUM, 64, physical registers; PR_W = clog2(PR_NUM)
- CKPT_NUM, 4, branch checkpoints (power of 2); CK_W = clog2(CKPT_NUM)
- clk  in  1  clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- flush  in  1  exception flush: sRAT <= aRAT, all checkpoints dropped
- ren_dest_en  in  RENAME_W  slot k writes a destination
- ren_dest_ar  in  RENAME_W*AR_W  destination AR per slot
- ren_dest_pr  in  RENAME_W*PR_W  newly allocated PR per slot
- ren_src_ar  in  2*RENAME_W*AR_W  two source ARs per slot (src j of slot k at index 2k+j)
- ren_src_pr  out  2*RENAME_W*PR_W  renamed sources (combinational)
- ren_old_pr  out  RENAME_W*PR_W  previous mapping of each dest AR (combinational, for ROB/free list)
- ckpt_alloc  in  1  group contains a branch; take a checkpoint
- ckpt_slot  in  clog2(RENAME_W)  slot index of that branch
- ckpt_id  out  CK_W  id assigned to the allocation (equals tail; combinational)
- ckpt_full  out  1  no free checkpoint; upstream must stall any branch group
- ckpt_restore  in  1  mispredict recovery
- ckpt_restore_id  in  CK_W  checkpoint to restore
- ckpt_release  in  1  oldest checkpoint's branch resolved correctly
- ret_dest_en  in  RETIRE_W  retire slot commits a mapping
- ret_dest_ar  in  RETIRE_W*AR_W  committed AR
- ret_dest_pr  in  RETIRE_W*PR_W  committed PR

## Operation
- Reset: sRAT[i] = i, aRAT[i] = i, every checkpoint entry = identity, head = tail = count = 0, ckpt_full = 0.
- AR 0 is hardwired zero:
  - dest writes to AR 0 are ignored in the sRAT, aRAT and checkpoints.
  - source lookup of AR 0 always returns PR 0.
- Source lookup, src j of slot k: take the dest PR of the highest slot m < k with ren_dest_en[m] and ren_dest_ar[m] equal to the source AR. If no such slot exists, return the current sRAT entry.
- ren_old_pr[k]: same rule applied to ren_dest_ar[k]. Valid only when ren_dest_en[k]=1; otherwise don't-care.
- sRAT update: every enabled slot writes. On an AR conflict the highest slot wins.
- Checkpoint on ckpt_alloc && !ckpt_full:
  - snapshot[tail] <= sRAT with slots 0..ckpt_slot applied (same conflict rule).
  - tail++ (mod CKPT_NUM), count++.
  - ckpt_alloc while ckpt_full is ignored and flagged by an assertion.
- ckpt_release: head++, count--. Release with count = 0 is illegal (assertion).
- ckpt_restore:
  - sRAT <= snapshot[ckpt_restore_id]; that checkpoint and all younger ones are discarded.
  - tail <= ckpt_restore_id+1 (mod CKPT_NUM).
  - count <= (ckpt_restore_id − head mod CKPT_NUM) + 1, minus 1 if ckpt_release is also asserted.
  - Restoring the head while releasing it is illegal (assertion).
- aRAT update: every enabled retire slot writes ret_dest_pr (highest slot wins). This happens every cycle and is unaffected by flush and restore.
- Priority for sRAT and checkpoints: rst > flush > ckpt_restore > rename/alloc.
  - flush: head = tail = count = 0. The retire writes of the same cycle are included in the sRAT copy, i.e. sRAT <= aRAT-next.
  - Rename writes and alloc in a restore or flush cycle are dropped.
- ckpt_full = (count == CKPT_NUM), registered.

## Timing
- Lookups and ckpt_id are combinational from inputs and state; zero latency.
- All map and pointer updates take effect at the next clk edge; a group renamed in cycle t sees group t−1's writes.
- Restore and flush take 1 cycle: renames in cycle t+1 see the recovered map.
- ckpt_full updates the cycle after the allocation/release that changes count.
- rst asserted mid-operation returns every state element to its reset value asynchronously.

## Structure
- Shared package `rename_pkg`: AR_W/PR_W/CK_W derivation functions, `ar_t`, `pr_t` and `ckpt_id_t` typedefs, and the ZERO_AR constant.
- Sub-module `rat_group_bypass`: priority-match an AR against earlier-slot dests, falling back to a table value. It is instantiated for each source, for each ren_old_pr, and for the snapshot merge.

## Test plan
- Reset, then lookup of AR 5 → PR 5; ckpt_full = 0; count = 0.
- Group slot0 r3→40, slot1 src r3 and dest r3→41, slot2 src r3 → slot1 src = 40, slot2 src = 41, old_pr[1] = 40; next cycle sRAT[3] = 41.
- Dest r0→50 → ignored; lookup r0 = PR 0.
- Four allocs → ckpt_full = 1 on the next cycle; fifth alloc ignored; one release → ckpt_full = 0.
- Alloc at slot1 (r4→42 in slot1, r4→43 in slot3), rename r4→44 later, restore that id → lookup r4 = 42; younger checkpoints gone; count recomputed.
- Retire r7→45, then flush in the same cycle as retire r8→46 → sRAT[7] = 45, sRAT[8] = 46, count = 0; rst pulsed mid-stream → identity maps.
